// File: rtl/drive_input_encoder_pkg.sv
// rtl/drive_input_encoder_pkg.sv - scan codes, axis encodings and parser states for the drive input encoder
package drive_input_encoder_pkg;

  localparam logic [7:0] SC_W      = 8'h1D;
  localparam logic [7:0] SC_S      = 8'h1B;
  localparam logic [7:0] SC_A      = 8'h1C;
  localparam logic [7:0] SC_D      = 8'h23;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;

  localparam logic [1:0] CODE_NONE  = 2'd0;
  localparam logic [1:0] CODE_LEFT  = 2'd1;
  localparam logic [1:0] CODE_RIGHT = 2'd2;
  localparam logic [1:0] CODE_UP    = 2'd1;
  localparam logic [1:0] CODE_DOWN  = 2'd2;

  // Game-state value in which the physics engines consume drive levels
  localparam logic [2:0] RACE_STATE_CODE = 3'd4;

  localparam int K_P1_UP    = 0;
  localparam int K_P1_DOWN  = 1;
  localparam int K_P1_LEFT  = 2;
  localparam int K_P1_RIGHT = 3;
  localparam int K_P1_BOOST = 4;
  localparam int K_P2_UP    = 5;
  localparam int K_P2_DOWN  = 6;
  localparam int K_P2_LEFT  = 7;
  localparam int K_P2_RIGHT = 8;
  localparam int K_P2_BOOST = 9;
  localparam int K_ENTER    = 10;
  localparam int NUM_KEYS   = 11;

  typedef enum logic [1:0] {
    PS_IDLE,
    PS_EXT,
    PS_BRK,
    PS_EXT_BRK
  } parse_state_e;

  // neg = left/up (code 1), pos = right/down (code 2); ties go to the last fresh press
  function automatic logic [1:0] axis_code(input logic neg_held, input logic pos_held,
                                           input logic last_pos);
    logic [1:0] c;
    case ({neg_held, pos_held})
      2'b10:   c = CODE_LEFT;
      2'b01:   c = CODE_RIGHT;
      2'b11:   c = last_pos ? CODE_RIGHT : CODE_LEFT;
      default: c = CODE_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/drive_input_encoder_axis_arbiter.sv
// rtl/drive_input_encoder_axis_arbiter.sv - held bits and last-pressed-wins resolution for one axis
module drive_input_encoder_axis_arbiter
  import drive_input_encoder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       neg_make,
  input  logic       neg_break,
  input  logic       pos_make,
  input  logic       pos_break,
  output logic [1:0] code
);

  logic neg_q, neg_d;
  logic pos_q, pos_d;
  logic last_q, last_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q  <= 1'b0;
      pos_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      neg_q  <= neg_d;
      pos_q  <= pos_d;
      last_q <= last_d;
    end
  end

  // Typematic repeats of an already-held key must not steal the axis
  always_comb begin
    neg_d  = neg_q;
    pos_d  = pos_q;
    last_d = last_q;
    if (neg_make) begin
      neg_d = 1'b1;
      if (!neg_q) last_d = 1'b0;
    end
    if (neg_break) neg_d = 1'b0;
    if (pos_make) begin
      pos_d = 1'b1;
      if (!pos_q) last_d = 1'b1;
    end
    if (pos_break) pos_d = 1'b0;
  end

  // Resolved from next-state so the top can register it with one cycle of latency
  assign code = axis_code(neg_d, pos_d, last_d);

endmodule

// File: rtl/drive_input_encoder.sv
// rtl/drive_input_encoder.sv - PS/2 set-2 byte stream to per-car drive levels and menu start pulse
module drive_input_encoder
  import drive_input_encoder_pkg::*;
#(
  parameter int         CLK_FREQ       = 100_000_000,
  parameter int         PREFIX_TIMEOUT = CLK_FREQ / 500,
  parameter logic [2:0] RACE_STATE     = RACE_STATE_CODE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic [2:0] state,
  output logic [1:0] p1_h_code,
  output logic [1:0] p1_v_code,
  output logic       p1_boost,
  output logic [1:0] p2_h_code,
  output logic [1:0] p2_v_code,
  output logic       p2_boost,
  output logic       start_pulse
);

  localparam int CW = $clog2(PREFIX_TIMEOUT + 1);

  parse_state_e ps_q, ps_d, ps_cur;
  logic [CW-1:0] cnt_q, cnt_d;
  logic timed_out, ev_make, ev_brk, ev_ext;
  logic [NUM_KEYS-1:0] key_hit, mk, bk;
  logic b1_q, b1_d, b2_q, b2_d, enter_q, enter_d, start_d, race;
  logic [1:0] p1_h_nxt, p1_v_nxt, p2_h_nxt, p2_v_nxt;
  logic [1:0] p1_h_q, p1_v_q, p2_h_q, p2_v_q;
  logic p1_b_q, p2_b_q, start_q;

  // A stale prefix is dropped before the current byte is parsed
  always_comb begin
    timed_out = (ps_q != PS_IDLE) && (cnt_q == CW'(PREFIX_TIMEOUT));
    ps_cur    = timed_out ? PS_IDLE : ps_q;
    ps_d      = ps_cur;
    ev_make   = 1'b0;
    ev_brk    = 1'b0;
    ev_ext    = 1'b0;
    if (byte_valid) begin
      case (ps_cur)
        PS_IDLE: begin
          if (byte_data == SC_EXT)      ps_d = PS_EXT;
          else if (byte_data == SC_BRK) ps_d = PS_BRK;
          else                          ev_make = 1'b1;
        end
        PS_EXT: begin
          if (byte_data == SC_BRK) ps_d = PS_EXT_BRK;
          else if (byte_data != SC_EXT) begin
            ev_make = 1'b1;
            ev_ext  = 1'b1;
            ps_d    = PS_IDLE;
          end
        end
        PS_BRK: begin
          ev_brk = 1'b1;
          ps_d   = PS_IDLE;
        end
        default: begin
          ev_brk = 1'b1;
          ev_ext = 1'b1;
          ps_d   = PS_IDLE;
        end
      endcase
    end
    if (byte_valid)             cnt_d = '0;
    else if (ps_cur != PS_IDLE) cnt_d = cnt_q + CW'(1);
    else                        cnt_d = '0;
  end

  always_comb begin
    key_hit = '0;
    if (!ev_ext) begin
      case (byte_data)
        SC_W:      key_hit[K_P1_UP]    = 1'b1;
        SC_S:      key_hit[K_P1_DOWN]  = 1'b1;
        SC_A:      key_hit[K_P1_LEFT]  = 1'b1;
        SC_D:      key_hit[K_P1_RIGHT] = 1'b1;
        SC_LSHIFT: key_hit[K_P1_BOOST] = 1'b1;
        SC_RSHIFT: key_hit[K_P2_BOOST] = 1'b1;
        SC_ENTER:  key_hit[K_ENTER]    = 1'b1;
        default:   ;
      endcase
    end else begin
      case (byte_data)
        SC_UP:    key_hit[K_P2_UP]    = 1'b1;
        SC_DOWN:  key_hit[K_P2_DOWN]  = 1'b1;
        SC_LEFT:  key_hit[K_P2_LEFT]  = 1'b1;
        SC_RIGHT: key_hit[K_P2_RIGHT] = 1'b1;
        default:  ;
      endcase
    end
    mk = ev_make ? key_hit : '0;
    bk = ev_brk  ? key_hit : '0;
  end

  always_comb begin
    b1_d    = (b1_q    | mk[K_P1_BOOST]) & ~bk[K_P1_BOOST];
    b2_d    = (b2_q    | mk[K_P2_BOOST]) & ~bk[K_P2_BOOST];
    enter_d = (enter_q | mk[K_ENTER])    & ~bk[K_ENTER];
    start_d = mk[K_ENTER] & ~enter_q;
    race    = (state == RACE_STATE);
  end

  drive_input_encoder_axis_arbiter u_p1_h (
    .clk(clk), .rst(rst),
    .neg_make(mk[K_P1_LEFT]), .neg_break(bk[K_P1_LEFT]),
    .pos_make(mk[K_P1_RIGHT]), .pos_break(bk[K_P1_RIGHT]),
    .code(p1_h_nxt)
  );

  drive_input_encoder_axis_arbiter u_p1_v (
    .clk(clk), .rst(rst),
    .neg_make(mk[K_P1_UP]), .neg_break(bk[K_P1_UP]),
    .pos_make(mk[K_P1_DOWN]), .pos_break(bk[K_P1_DOWN]),
    .code(p1_v_nxt)
  );

  drive_input_encoder_axis_arbiter u_p2_h (
    .clk(clk), .rst(rst),
    .neg_make(mk[K_P2_LEFT]), .neg_break(bk[K_P2_LEFT]),
    .pos_make(mk[K_P2_RIGHT]), .pos_break(bk[K_P2_RIGHT]),
    .code(p2_h_nxt)
  );

  drive_input_encoder_axis_arbiter u_p2_v (
    .clk(clk), .rst(rst),
    .neg_make(mk[K_P2_UP]), .neg_break(bk[K_P2_UP]),
    .pos_make(mk[K_P2_DOWN]), .pos_break(bk[K_P2_DOWN]),
    .code(p2_v_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_q    <= PS_IDLE;
      cnt_q   <= '0;
      b1_q    <= 1'b0;
      b2_q    <= 1'b0;
      enter_q <= 1'b0;
      p1_h_q  <= CODE_NONE;
      p1_v_q  <= CODE_NONE;
      p2_h_q  <= CODE_NONE;
      p2_v_q  <= CODE_NONE;
      p1_b_q  <= 1'b0;
      p2_b_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      ps_q    <= ps_d;
      cnt_q   <= cnt_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      enter_q <= enter_d;
      // Held bits keep tracking outside the race; only the drive levels are masked
      p1_h_q  <= race ? p1_h_nxt : CODE_NONE;
      p1_v_q  <= race ? p1_v_nxt : CODE_NONE;
      p2_h_q  <= race ? p2_h_nxt : CODE_NONE;
      p2_v_q  <= race ? p2_v_nxt : CODE_NONE;
      p1_b_q  <= race & b1_d;
      p2_b_q  <= race & b2_d;
      start_q <= start_d;
    end
  end

  assign p1_h_code   = p1_h_q;
  assign p1_v_code   = p1_v_q;
  assign p1_boost    = p1_b_q;
  assign p2_h_code   = p2_h_q;
  assign p2_v_code   = p2_v_q;
  assign p2_boost    = p2_b_q;
  assign start_pulse = start_q;

endmodule

// File: tb/tb_drive_input_encoder.sv
// tb/tb_drive_input_encoder.sv - directed and randomized checks of drive_input_encoder against a key-press model
module tb_drive_input_encoder;

  localparam int P = 10_000 / 500;

  logic       clk = 1'b0;
  logic       rst;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic [2:0] gstate;
  logic [1:0] p1_h_code, p1_v_code, p2_h_code, p2_v_code;
  logic       p1_boost, p2_boost, start_pulse;

  int vectors = 0;
  int miscompares = 0;

  drive_input_encoder #(.CLK_FREQ(10_000)) dut (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data), .state(gstate),
    .p1_h_code(p1_h_code), .p1_v_code(p1_v_code), .p1_boost(p1_boost),
    .p2_h_code(p2_h_code), .p2_v_code(p2_v_code), .p2_boost(p2_boost),
    .start_pulse(start_pulse)
  );

  always #5 clk = ~clk;

  // Model: per-key held flag plus the time of its most recent fresh press
  bit          held [11];
  int unsigned press_t [11];
  int unsigned tick;
  bit          pend_ext, pend_brk;
  int          gap;
  logic [1:0]  e_p1h, e_p1v, e_p2h, e_p2v;
  logic        e_p1b, e_p2b, e_start;

  logic [7:0] pool [18] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h12, 8'h59, 8'h5A, 8'h75, 8'h72,
                            8'h6B, 8'h74, 8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'hF0, 8'h7C, 8'h00};

  function automatic int key_of(input bit ext, input logic [7:0] b);
    if (!ext) begin
      case (b)
        8'h1D: return 0;
        8'h1B: return 1;
        8'h1C: return 2;
        8'h23: return 3;
        8'h12: return 4;
        8'h59: return 9;
        8'h5A: return 10;
        default: return -1;
      endcase
    end
    case (b)
      8'h75: return 5;
      8'h72: return 6;
      8'h6B: return 7;
      8'h74: return 8;
      default: return -1;
    endcase
  endfunction

  function automatic logic [1:0] axis(input int n, input int p);
    if (held[n] && held[p]) return (press_t[p] > press_t[n]) ? 2'd2 : 2'd1;
    if (held[n]) return 2'd1;
    if (held[p]) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_outputs();
    bit race;
    race  = (gstate == 3'd4);
    e_p1h = race ? axis(2, 3) : 2'd0;
    e_p1v = race ? axis(0, 1) : 2'd0;
    e_p2h = race ? axis(7, 8) : 2'd0;
    e_p2v = race ? axis(5, 6) : 2'd0;
    e_p1b = race & held[4];
    e_p2b = race & held[9];
  endtask

  task automatic model_reset();
    for (int k = 0; k < 11; k++) begin
      held[k] = 0;
      press_t[k] = 0;
    end
    tick = 0; pend_ext = 0; pend_brk = 0; gap = 0; e_start = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int k;
    e_start = 0;
    if ((pend_ext || pend_brk) && gap >= P) begin
      pend_ext = 0;
      pend_brk = 0;
    end
    gap = 0;
    if (pend_brk) begin
      k = key_of(pend_ext, b);
      if (k >= 0) held[k] = 0;
      pend_ext = 0; pend_brk = 0;
    end else if (b == 8'hE0) begin
      pend_ext = 1;
    end else if (b == 8'hF0) begin
      pend_brk = 1;
    end else begin
      k = key_of(pend_ext, b);
      if (k >= 0 && !held[k]) begin
        held[k] = 1;
        tick++;
        press_t[k] = tick;
        if (k == 10) e_start = 1;
      end
      pend_ext = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    model_byte(b);
    model_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      gap++;
    end
    e_start = 0;
    model_outputs();
  endtask

  task automatic set_state(input logic [2:0] s);
    gstate = s;
    @(negedge clk);
    gap++;
    e_start = 0;
    model_outputs();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    model_outputs();
  endtask

  task automatic test_reset();
    rst = 1'b1; byte_valid = 1'b1; byte_data = 8'h1D; gstate = 3'd4;
    @(negedge clk);
    byte_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    model_outputs();
    vectors++; if ({p1_h_code, p1_v_code, p1_boost} !== 5'd0) begin miscompares++; $display("FAIL reset_p1: got %b want 00000", {p1_h_code, p1_v_code, p1_boost}); end
    vectors++; if ({p2_h_code, p2_v_code, p2_boost} !== 5'd0) begin miscompares++; $display("FAIL reset_p2: got %b want 00000", {p2_h_code, p2_v_code, p2_boost}); end
    vectors++; if (start_pulse !== 1'b0) begin miscompares++; $display("FAIL reset_start: got %b want 0", start_pulse); end
  endtask

  task automatic test_basic();
    send_byte(8'h1D);
    vectors++; if (p1_v_code !== 2'd1) begin miscompares++; $display("FAIL basic_w_up: p1_v=%0d want 1", p1_v_code); end
    vectors++; if (p1_h_code !== 2'd0) begin miscompares++; $display("FAIL basic_h_idle: p1_h=%0d want 0", p1_h_code); end
    send_byte(8'h1C);
    vectors++; if (p1_h_code !== 2'd1) begin miscompares++; $display("FAIL basic_a_left: p1_h=%0d want 1", p1_h_code); end
    send_byte(8'hF0); send_byte(8'h1D);
    vectors++; if (p1_v_code !== 2'd0) begin miscompares++; $display("FAIL basic_w_break: p1_v=%0d want 0", p1_v_code); end
    vectors++; if (p1_h_code !== 2'd1) begin miscompares++; $display("FAIL basic_a_kept: p1_h=%0d want 1", p1_h_code); end
    send_byte(8'hF0); send_byte(8'h1C);
  endtask

  task automatic test_last_wins();
    send_byte(8'h1C); send_byte(8'h23);
    vectors++; if (p1_h_code !== 2'd2) begin miscompares++; $display("FAIL lw_d_last: p1_h=%0d want 2", p1_h_code); end
    send_byte(8'hF0); send_byte(8'h23);
    vectors++; if (p1_h_code !== 2'd1) begin miscompares++; $display("FAIL lw_d_released: p1_h=%0d want 1", p1_h_code); end
    send_byte(8'h23);
    send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
    vectors++; if (p1_h_code !== 2'd2) begin miscompares++; $display("FAIL lw_typematic: p1_h=%0d want 2", p1_h_code); end
    send_byte(8'h1B); send_byte(8'h1D);
    vectors++; if (p1_v_code !== 2'd1) begin miscompares++; $display("FAIL lw_v_up_last: p1_v=%0d want 1", p1_v_code); end
    send_byte(8'hF0); send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h23);
    send_byte(8'hF0); send_byte(8'h1B); send_byte(8'hF0); send_byte(8'h1D);
    vectors++; if ({p1_h_code, p1_v_code} !== 4'd0) begin miscompares++; $display("FAIL lw_all_released: got %b want 0000", {p1_h_code, p1_v_code}); end
  endtask

  task automatic test_p2();
    send_byte(8'hE0); send_byte(8'h75);
    vectors++; if (p2_v_code !== 2'd1) begin miscompares++; $display("FAIL p2_up: p2_v=%0d want 1", p2_v_code); end
    send_byte(8'hE0); send_byte(8'h6B);
    vectors++; if (p2_h_code !== 2'd1) begin miscompares++; $display("FAIL p2_left: p2_h=%0d want 1", p2_h_code); end
    send_byte(8'h59);
    vectors++; if (p2_boost !== 1'b1) begin miscompares++; $display("FAIL p2_boost: got %b want 1", p2_boost); end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    vectors++; if (p2_v_code !== 2'd0) begin miscompares++; $display("FAIL p2_up_break: p2_v=%0d want 0", p2_v_code); end
    vectors++; if ({p1_h_code, p1_v_code, p1_boost} !== 5'd0) begin miscompares++; $display("FAIL p2_p1_quiet: got %b want 00000", {p1_h_code, p1_v_code, p1_boost}); end
    send_byte(8'h12); send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h12);
    vectors++; if (p1_boost !== 1'b1) begin miscompares++; $display("FAIL ext12_filler: p1_boost=%b want 1", p1_boost); end
    send_byte(8'hF0); send_byte(8'h12);
    vectors++; if (p1_boost !== 1'b0) begin miscompares++; $display("FAIL lshift_break: p1_boost=%b want 0", p1_boost); end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B); send_byte(8'hF0); send_byte(8'h59);
  endtask

  task automatic test_state_gate();
    set_state(3'd2);
    send_byte(8'h1D);
    vectors++; if (p1_v_code !== 2'd0) begin miscompares++; $display("FAIL gate_masked: p1_v=%0d want 0", p1_v_code); end
    set_state(3'd4);
    vectors++; if (p1_v_code !== 2'd1) begin miscompares++; $display("FAIL gate_enter_race: p1_v=%0d want 1", p1_v_code); end
    set_state(3'd2);
    send_byte(8'h5A);
    vectors++; if (start_pulse !== 1'b1) begin miscompares++; $display("FAIL start_pulse: got %b want 1", start_pulse); end
    idle(1);
    vectors++; if (start_pulse !== 1'b0) begin miscompares++; $display("FAIL start_one_cycle: got %b want 0", start_pulse); end
    send_byte(8'h5A);
    vectors++; if (start_pulse !== 1'b0) begin miscompares++; $display("FAIL start_repeat: got %b want 0", start_pulse); end
    send_byte(8'hE0); send_byte(8'h5A);
    vectors++; if (start_pulse !== 1'b0) begin miscompares++; $display("FAIL start_ext: got %b want 0", start_pulse); end
    send_byte(8'hF0); send_byte(8'h5A); send_byte(8'h5A);
    vectors++; if (start_pulse !== 1'b1) begin miscompares++; $display("FAIL start_again: got %b want 1", start_pulse); end
    send_byte(8'hF0); send_byte(8'h5A); send_byte(8'hF0); send_byte(8'h1D);
    set_state(3'd4);
  endtask

  task automatic test_timeout();
    send_byte(8'hE0); idle(P); send_byte(8'h75);
    vectors++; if (p2_v_code !== 2'd0) begin miscompares++; $display("FAIL to_ext_dropped: p2_v=%0d want 0", p2_v_code); end
    send_byte(8'hE0); idle(P - 1); send_byte(8'h75);
    vectors++; if (p2_v_code !== 2'd1) begin miscompares++; $display("FAIL to_ext_kept: p2_v=%0d want 1", p2_v_code); end
    send_byte(8'hF0); idle(P); send_byte(8'h75);
    vectors++; if (p2_v_code !== 2'd1) begin miscompares++; $display("FAIL to_brk_dropped: p2_v=%0d want 1", p2_v_code); end
    send_byte(8'hE0); send_byte(8'hF0); idle(P); send_byte(8'h75);
    vectors++; if (p2_v_code !== 2'd1) begin miscompares++; $display("FAIL to_extbrk_dropped: p2_v=%0d want 1", p2_v_code); end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    vectors++; if (p2_v_code !== 2'd0) begin miscompares++; $display("FAIL to_clean_break: p2_v=%0d want 0", p2_v_code); end
  endtask

  task automatic test_rst_mid();
    send_byte(8'hE0); send_byte(8'h75); send_byte(8'h1D);
    send_byte(8'hE0);
    pulse_reset();
    vectors++; if ({p2_v_code, p1_v_code} !== 4'd0) begin miscompares++; $display("FAIL rst_outputs: got %b want 0000", {p2_v_code, p1_v_code}); end
    idle(1);
    vectors++; if ({p2_v_code, p1_v_code} !== 4'd0) begin miscompares++; $display("FAIL rst_held_cleared: got %b want 0000", {p2_v_code, p1_v_code}); end
    send_byte(8'hF0); send_byte(8'h75);
    vectors++; if (p2_v_code !== 2'd0) begin miscompares++; $display("FAIL rst_75_unmapped: p2_v=%0d want 0", p2_v_code); end
    send_byte(8'hE0); send_byte(8'h75);
    vectors++; if (p2_v_code !== 2'd1) begin miscompares++; $display("FAIL rst_recover: p2_v=%0d want 1", p2_v_code); end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      if (r < 10)      idle($urandom_range(1, P + 3));
      else if (r < 15) set_state(($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd4);
      else             send_byte(pool[$urandom_range(0, 17)]);
      vectors++; if (p1_h_code !== e_p1h) begin miscompares++; $display("FAIL rnd_p1_h step %0d: got %0d want %0d", i, p1_h_code, e_p1h); end
      vectors++; if (p1_v_code !== e_p1v) begin miscompares++; $display("FAIL rnd_p1_v step %0d: got %0d want %0d", i, p1_v_code, e_p1v); end
      vectors++; if (p1_boost !== e_p1b) begin miscompares++; $display("FAIL rnd_p1_boost step %0d: got %b want %b", i, p1_boost, e_p1b); end
      vectors++; if (p2_h_code !== e_p2h) begin miscompares++; $display("FAIL rnd_p2_h step %0d: got %0d want %0d", i, p2_h_code, e_p2h); end
      vectors++; if (p2_v_code !== e_p2v) begin miscompares++; $display("FAIL rnd_p2_v step %0d: got %0d want %0d", i, p2_v_code, e_p2v); end
      vectors++; if (p2_boost !== e_p2b) begin miscompares++; $display("FAIL rnd_p2_boost step %0d: got %b want %b", i, p2_boost, e_p2b); end
      vectors++; if (start_pulse !== e_start) begin miscompares++; $display("FAIL rnd_start step %0d: got %b want %b", i, start_pulse, e_start); end
    end
  endtask

  initial begin
    rst = 1'b1; byte_valid = 1'b0; byte_data = 8'h00; gstate = 3'd4;
    @(negedge clk);
    test_reset();
    test_basic();
    test_last_wins();
    test_p2();
    test_state_gate();
    test_timeout();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
